// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter: the FSM state encoding
// and the grant-index width function.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Grant index width, never narrower than one bit.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: picks the first asserted request searching
// upward from one past the previous winner, wrapping at NUM_REQ.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_last,
  output logic [IDW-1:0]     o_winner,
  output logic               o_any
);

  int             w_idx;
  logic [IDW-1:0] w_sel;
  logic           w_found;

  always_comb begin
    o_winner = '0;
    o_any    = |i_req;
    w_found  = 1'b0;
    w_idx    = 0;
    w_sel    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(i_last) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_sel = IDW'(w_idx);
      if (!w_found && i_req[w_sel]) begin
        w_found  = 1'b1;
        o_winner = w_sel;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter granting whole bursts onto one shared FIFO write port.
// Define FIFO_ARB_TAG_EN to prepend the grant index to every FIFO word.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int IDW        = idw(NUM_REQ),
`ifdef FIFO_ARB_TAG_EN
  localparam int FW         = DATA_WIDTH + IDW
`else
  localparam int FW         = DATA_WIDTH
`endif
) (
  input  logic                          ACLK,
  input  logic                          ARESET_N,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FIFO_FULL,
  output logic                          FIFO_WR_EN,
  output logic [FW-1:0]                 FIFO_DATA_IN,
  output logic [IDW-1:0]                GRANT_ID,
  output logic                          BUSY
);

  arb_state_e            r_state;
  logic [IDW-1:0]        r_grant_id;
  logic [IDW-1:0]        r_last_winner;
  logic                  r_busy;

  logic [IDW-1:0]        w_winner;
  logic                  w_any;
  logic                  w_locked;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_payload;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req    (REQ_VALID),
    .i_last   (r_last_winner),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_locked = (r_state == LOCKED);

  // Select the granted requester's valid/last/payload with a one-hot compare.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_payload   = '0;
    REQ_READY   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == IDW'(i)) begin
        w_sel_valid  = REQ_VALID[i];
        w_sel_last   = REQ_LAST[i];
        w_payload    = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        REQ_READY[i] = w_locked && !FIFO_FULL;
      end
    end
  end

  assign w_accept   = w_locked && w_sel_valid && !FIFO_FULL;
  assign FIFO_WR_EN = w_accept;
  assign GRANT_ID   = r_grant_id;
  assign BUSY       = r_busy;

`ifdef FIFO_ARB_TAG_EN
  assign FIFO_DATA_IN = {r_grant_id, w_payload};
`else
  assign FIFO_DATA_IN = w_payload;
`endif

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_grant_id    <= '0;
      r_last_winner <= IDW'(NUM_REQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state    <= LOCKED;
            r_busy     <= 1'b1;
            r_grant_id <= w_winner;
          end
        end
        LOCKED: begin
          // Grant is released only by an accepted last beat.
          if (w_accept && w_sel_last) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_last_winner <= r_grant_id;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8); the tagged
// FIFO word check is compiled in when FIFO_ARB_TAG_EN is defined.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

`ifdef FIFO_ARB_TAG_EN
  localparam int FW = 10;
`else
  localparam int FW = 8;
`endif

  logic          ACLK;
  logic          ARESET_N;
  logic [3:0]    REQ_VALID;
  logic [3:0]    REQ_LAST;
  logic [31:0]   REQ_DATA;
  logic [3:0]    REQ_READY;
  logic          FIFO_FULL;
  logic          FIFO_WR_EN;
  logic [FW-1:0] FIFO_DATA_IN;
  logic [1:0]    GRANT_ID;
  logic          BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_write_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8)
  ) dut (
    .ACLK         (ACLK),
    .ARESET_N     (ARESET_N),
    .REQ_VALID    (REQ_VALID),
    .REQ_LAST     (REQ_LAST),
    .REQ_DATA     (REQ_DATA),
    .REQ_READY    (REQ_READY),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_WR_EN   (FIFO_WR_EN),
    .FIFO_DATA_IN (FIFO_DATA_IN),
    .GRANT_ID     (GRANT_ID),
    .BUSY         (BUSY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected FIFO word for a given grant index and payload.
  function automatic logic [31:0] exp_word(input logic [1:0] id, input logic [7:0] pl);
`ifdef FIFO_ARB_TAG_EN
    return {22'd0, id, pl};
`else
    return {24'd0, pl};
`endif
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_wr"}, 32'(FIFO_WR_EN), 32'd0);
    chk({tag, "_rdy"}, 32'(REQ_READY), 32'd0);
  endtask

  task automatic chk_write(input string tag, input logic [1:0] id, input logic [7:0] pl);
    chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    chk({tag, "_gid"}, 32'(GRANT_ID), 32'(id));
    chk({tag, "_wr"}, 32'(FIFO_WR_EN), 32'd1);
    chk({tag, "_rdy"}, 32'(REQ_READY), 32'(4'b0001 << id));
    chk({tag, "_data"}, 32'(FIFO_DATA_IN), exp_word(id, pl));
  endtask

  initial begin
    ARESET_N  = 1'b0;
    REQ_VALID = 4'b0000;
    REQ_LAST  = 4'b0000;
    REQ_DATA  = 32'h13121110;
    FIFO_FULL = 1'b0;

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    chk_idle("rst");
    chk("rst_gid", 32'(GRANT_ID), 32'd0);

    // Requesters 0 and 2, single-beat bursts: grant 0, idle cycle, grant 2
    ARESET_N  = 1'b1;
    REQ_VALID = 4'b0101;
    REQ_LAST  = 4'b1111;
    #1;
    chk_idle("t30_arb0");
    tick();
    chk_write("t30_g0", 2'd0, 8'h10);
    tick();
    REQ_VALID = 4'b0100;
    #1;
    chk_idle("t30_arb2");
    tick();
    chk_write("t30_g2", 2'd2, 8'h12);
    tick();
    REQ_VALID = 4'b0000;
    #1;
    chk_idle("t30_end");

    // Fresh reset, all four valid with single-beat bursts: 0,1,2,3,0,1,2,3
    ARESET_N = 1'b0;
    tick();
    ARESET_N  = 1'b1;
    REQ_VALID = 4'b1111;
    REQ_LAST  = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk_idle($sformatf("t31_arb%0d", k));
      tick();
      chk_write($sformatf("t31_g%0d", k), 2'(k % 4), 8'(8'h10 + k % 4));
      tick();
    end

    // Requester 1 three-beat burst holds the grant against requester 3
    REQ_VALID = 4'b1010;
    REQ_LAST  = 4'b1000;
    REQ_DATA[15:8] = 8'h20;
    #1;
    chk_idle("t32_arb1");
    tick();
    for (int b = 0; b < 3; b++) begin
      REQ_DATA[15:8] = 8'(8'h20 + b);
      REQ_LAST[1]    = (b == 2);
      #1;
      chk_write($sformatf("t32_b%0d", b), 2'd1, 8'(8'h20 + b));
      tick();
    end
    REQ_VALID = 4'b1000;
    #1;
    chk_idle("t32_arb3");
    tick();
    chk_write("t32_g3", 2'd3, 8'h13);
    tick();

    // Requester 0 burst with FIFO_FULL for five cycles and a valid gap
    REQ_VALID = 4'b0001;
    REQ_LAST  = 4'b0000;
    REQ_DATA[7:0] = 8'h30;
    #1;
    chk_idle("t33_arb");
    tick();
    chk_write("t33_b0", 2'd0, 8'h30);
    tick();
    REQ_DATA[7:0] = 8'h31;
    FIFO_FULL = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t33_full%0d_wr", c), 32'(FIFO_WR_EN), 32'd0);
      chk($sformatf("t33_full%0d_rdy", c), 32'(REQ_READY), 32'd0);
      chk($sformatf("t33_full%0d_busy", c), 32'(BUSY), 32'd1);
      tick();
    end
    FIFO_FULL = 1'b0;
    #1;
    chk_write("t33_b1", 2'd0, 8'h31);
    tick();
    REQ_VALID = 4'b0000;
    #1;
    chk("t33_gap_wr", 32'(FIFO_WR_EN), 32'd0);
    chk("t33_gap_busy", 32'(BUSY), 32'd1);
    chk("t33_gap_rdy", 32'(REQ_READY), 32'b0001);
    tick();
    REQ_VALID = 4'b0001;
    REQ_LAST  = 4'b0001;
    REQ_DATA[7:0] = 8'h32;
    #1;
    chk_write("t33_b2", 2'd0, 8'h32);
    tick();
    REQ_VALID = 4'b0000;
    #1;
    chk_idle("t33_end");

    // Reset pulsed during a requester 2 burst; requester 0 wins afterwards
    REQ_VALID = 4'b0100;
    REQ_LAST  = 4'b0000;
    REQ_DATA  = 32'h13121110;
    #1;
    tick();
    chk_write("t34_b0", 2'd2, 8'h12);
    tick();
    ARESET_N = 1'b0;
    #1;
    chk_idle("t34_rst");
    chk("t34_rst_gid", 32'(GRANT_ID), 32'd0);
    REQ_VALID = 4'b1111;
    REQ_LAST  = 4'b1111;
    tick();
    ARESET_N = 1'b1;
    #1;
    chk_idle("t34_arb");
    tick();
    chk_write("t34_g0", 2'd0, 8'h10);
    tick();
    REQ_VALID = 4'b0000;
    #1;

`ifdef FIFO_ARB_TAG_EN
    // Tagged word from requester 3
    REQ_VALID = 4'b1000;
    REQ_DATA[31:24] = 8'hA5;
    #1;
    tick();
    chk("t35_tag", 32'(FIFO_DATA_IN), 32'h3A5);
    chk("t35_wr", 32'(FIFO_WR_EN), 32'd1);
    tick();
    REQ_VALID = 4'b0000;
    #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one synchronous FIFO write port (legal 2..16).
REQ-002 Parameter DATA_WIDTH, default 8, payload width per requester.
REQ-003 ACLK  input  1  clock; all state updates on rising edge.
REQ-004 ARESET_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ_VALID  input  NUM_REQ  per-requester data valid.
REQ-006 REQ_LAST  input  NUM_REQ  per-requester last beat of burst, sampled only with REQ_VALID.
REQ-007 REQ_DATA  input  NUM_REQ*DATA_WIDTH  packed payloads, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 REQ_READY  output  NUM_REQ  per-requester beat accepted this cycle when high with REQ_VALID.
REQ-009 FIFO_FULL  input  1  full flag from the shared FIFO.
REQ-010 FIFO_WR_EN  output  1  write strobe to the shared FIFO.
REQ-011 FIFO_DATA_IN  output  FW  data to FIFO; FW = DATA_WIDTH, or DATA_WIDTH+IDW with tag (REQ-027), IDW = max(1,$clog2(NUM_REQ)).
REQ-012 GRANT_ID  output  IDW  index of current grant owner, valid while BUSY.
REQ-013 BUSY  output  1  high while a grant is held.

Function
REQ-014 FSM states IDLE and LOCKED, one-hot or encoded, registered.
REQ-015 IDLE: if any REQ_VALID high, winner = first requester with VALID searching from LAST_WINNER+1 upward, wrapping at NUM_REQ; next cycle LOCKED, GRANT_ID = winner, BUSY = 1.
REQ-016 IDLE with no REQ_VALID: stay IDLE; REQ_READY = 0, FIFO_WR_EN = 0.
REQ-017 Arbitration costs exactly one cycle: first beat of a burst is accepted no earlier than the cycle after REQ_VALID is first seen in IDLE.
REQ-018 LOCKED: REQ_READY[GRANT_ID] = !FIFO_FULL (combinational); all other REQ_READY bits = 0.
REQ-019 FIFO_WR_EN = LOCKED && REQ_VALID[GRANT_ID] && !FIFO_FULL; FIFO_DATA_IN = REQ_DATA slice of GRANT_ID, same cycle, no pipeline stage.
REQ-020 Beat with REQ_LAST = 1 accepted: next cycle IDLE, BUSY = 0, LAST_WINNER <= GRANT_ID.
REQ-021 Granted requester dropping REQ_VALID mid-burst: grant held, no write, no timeout.
REQ-022 FIFO_FULL high in LOCKED: no write, beat stalls, grant held; resumes cycle FIFO_FULL falls.
REQ-023 Requests from non-granted requesters never write and never preempt a held grant.
REQ-024 Round-robin fairness: with all requesters continuously valid and single-beat bursts, grants cycle 0,1,..,NUM_REQ-1,0 after reset.

Reset
REQ-025 ARESET_N low, asynchronously: state IDLE, BUSY = 0, GRANT_ID = 0, LAST_WINNER = NUM_REQ-1 (requester 0 has top priority first), REQ_READY = 0, FIFO_WR_EN = 0.
REQ-026 Reset mid-burst abandons the burst; no partial-burst recovery; first grant after release follows REQ-025 priority.

Configuration
REQ-027 Macro FIFO_ARB_TAG_EN defined: FIFO_DATA_IN = {GRANT_ID, payload}, width DATA_WIDTH+IDW; undefined: FIFO_DATA_IN = payload only, width DATA_WIDTH; all other behaviour identical.

Structure
REQ-028 Package fifo_arb_pkg holds the FSM state typedef (IDLE, LOCKED) and the IDW width function.
REQ-029 Sub-module rr_priority_picker: combinational, inputs request vector and last-winner index, outputs winner index and any-request flag; instantiated once.

Verification
REQ-030 Reset release, REQ_VALID=4'b0101, single-beat LAST on all -> grants 0 then 2; FIFO_WR_EN one cycle each, one idle arbitration cycle between.
REQ-031 All four valid continuously, LAST=1 each beat, 8 beats -> GRANT_ID sequence 0,1,2,3,0,1,2,3.
REQ-032 Requester 1 burst of 3 beats (LAST on third), requester 3 valid throughout -> three consecutive writes from 1 before any from 3.
REQ-033 Granted burst, FIFO_FULL high 5 cycles mid-burst -> FIFO_WR_EN=0 and REQ_READY=0 those cycles, no beat lost or duplicated.
REQ-034 ARESET_N pulsed low during a burst from requester 2 -> outputs reset same cycle; after release with all valid, requester 0 granted first.
REQ-035 FIFO_ARB_TAG_EN defined, requester 3 writes 8'hA5 with NUM_REQ=4 -> FIFO_DATA_IN = 10'h3A5.
